// File: rtl/mem_load_pkg.sv
// Shared definitions for the memory load/readback port.
// Holds the loader FSM state encoding, default widths, the NOP instruction
// constant used by the core wrapper, and a small width helper.
package mem_load_pkg;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } state_e;

    localparam int DW_DEF     = 16;
    localparam int AW_DEF     = 13;
    localparam int NCH_DEF    = 2;
    localparam int RD_LAT_DEF = 1;

    // Read-wait counter width; holds RD_LAT values up to 4.
    localparam int CNT_W = 3;

    // Instruction word the core wrapper feeds while memories are being loaded.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Select-field width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser with rising-edge detector for an asynchronous pad.
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   async_in asynchronous pin input
//   level    synchronised level
//   rise     one-cycle pulse on a synchronised 0->1 transition
module strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Shift the pin through the synchroniser and remember the last level.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/mem_load_port.sv
// Host loader/readback port for NCH processor memories.
// A host drives a narrow parallel bus with a four-phase strobe/ack handshake
// to load per-channel address registers and to write or read memory words;
// each memory access auto-increments that channel's address register.
// When start=1 the memories are handed to the processor datapath.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 1 = processor owns memories, 0 = loader mode
//   host_strobe           asynchronous command strobe
//   host_wr_rdb           1 = write, 0 = read
//   host_addr_memb        1 = address register target, 0 = memory target
//   host_ch, host_din     channel select, write data
//   host_dout, host_ack   registered readback data, acknowledge
//   busy                  loader FSM not idle
//   cpu_addr/wen_n/wdata  processor-side memory interface
//   mem_addr/wen_n/wdata  memory macro interface (muxed)
//   mem_rdata             memory read data
module mem_load_port
    import mem_load_pkg::*;
#(
    parameter  int DW     = 16,
    parameter  int AW     = 13,
    parameter  int NCH    = 2,
    parameter  int RD_LAT = 1,
    localparam int CW     = clog2_min1(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              host_strobe,
    input  logic              host_wr_rdb,
    input  logic              host_addr_memb,
    input  logic [CW-1:0]     host_ch,
    input  logic [DW-1:0]     host_din,
    output logic [DW-1:0]     host_dout,
    output logic              host_ack,
    output logic              busy,
    input  logic [NCH*AW-1:0] cpu_addr,
    input  logic [NCH-1:0]    cpu_wen_n,
    input  logic [NCH*DW-1:0] cpu_wdata,
    output logic [NCH*AW-1:0] mem_addr,
    output logic [NCH-1:0]    mem_wen_n,
    output logic [NCH*DW-1:0] mem_wdata,
    input  logic [NCH*DW-1:0] mem_rdata
);

    state_e             state_q, state_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [DW-1:0]      dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic [DW-1:0]      din_q, din_d;

    logic               strb_lvl_s, strb_rise_s;
    logic               cap_en_s, ld_en_s, inc_en_s;
    logic               host_ch_ok_s;
    logic [NCH*AW-1:0]  addr_all_s;
    logic [AW-1:0]      host_addr_sel_s;
    logic [DW-1:0]      addr_zext_s;
    logic [DW-1:0]      rdata_sel_s;

    strobe_sync u_strobe_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (host_strobe),
        .level    (strb_lvl_s),
        .rise     (strb_rise_s)
    );

    // Channel validity and per-channel selection of address / read data.
    always_comb begin
        host_ch_ok_s    = (32'(host_ch) < NCH);
        host_addr_sel_s = '0;
        rdata_sel_s     = '0;
        for (int k = 0; k < NCH; k++) begin
            host_addr_sel_s = (host_ch == CW'(k)) ? addr_all_s[k*AW +: AW] : host_addr_sel_s;
            rdata_sel_s     = (ch_q == CW'(k)) ? mem_rdata[k*DW +: DW] : rdata_sel_s;
        end
        addr_zext_s           = '0;
        addr_zext_s[AW-1:0]   = host_addr_sel_s;
    end

    // Loader FSM: next state, handshake, readback and address-register controls.
    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        cap_en_s = 1'b0;
        ld_en_s  = 1'b0;
        inc_en_s = 1'b0;
        if (start) begin
            // Processor takes over: abandon whatever the loader was doing.
            state_d = ST_IDLE;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (strb_rise_s) begin
                        cap_en_s = 1'b1;
                        if (!host_ch_ok_s) begin
                            dout_d  = '0;
                            ack_d   = 1'b1;
                            state_d = ST_ACK;
                        end else if (host_addr_memb) begin
                            if (host_wr_rdb) begin
                                ld_en_s = 1'b1;
                            end else begin
                                dout_d = addr_zext_s;
                            end
                            ack_d   = 1'b1;
                            state_d = ST_ACK;
                        end else if (host_wr_rdb) begin
                            state_d = ST_WRITE;
                        end else begin
                            cnt_d   = CNT_W'(RD_LAT);
                            state_d = ST_RD_WAIT;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    inc_en_s = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = ST_ACK;
                end
                ST_RD_WAIT: begin
                    // Address is presented from the first wait cycle; data is
                    // valid RD_LAT cycles later, when the counter hits zero.
                    if (cnt_q == '0) begin
                        dout_d   = rdata_sel_s;
                        inc_en_s = 1'b1;
                        ack_d    = 1'b1;
                        state_d  = ST_ACK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    if (!strb_lvl_s) begin
                        ack_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                default: begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        ch_d   = cap_en_s ? host_ch  : ch_q;
        din_d  = cap_en_s ? host_din : din_q;
    end

    // FSM, handshake, readback and command registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            din_q   <= din_d;
        end
    end

    assign host_ack  = ack_q;
    assign host_dout = dout_q;
    assign busy      = busy_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [AW-1:0] addr_q, addr_d;

        // Address register: explicit load, post-access increment, else hold.
        always_comb begin
            if (ld_en_s && (host_ch == CW'(k))) begin
                addr_d = host_din[AW-1:0];
            end else if (inc_en_s && (ch_q == CW'(k))) begin
                addr_d = addr_q + AW'(1);
            end else begin
                addr_d = addr_q;
            end
        end

        // Per-channel address register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                addr_q <= '0;
            end else begin
                addr_q <= addr_d;
            end
        end

        assign addr_all_s[k*AW +: AW] = addr_q;

        // Ownership mux is combinational on start so the processor sees its
        // memories in the same cycle it claims them.
        assign mem_addr[k*AW +: AW]  = start ? cpu_addr[k*AW +: AW] : addr_q;
        assign mem_wen_n[k]          = start ? cpu_wen_n[k]
                                             : ~((state_q == ST_WRITE) && (ch_q == CW'(k)));
        assign mem_wdata[k*DW +: DW] = start ? cpu_wdata[k*DW +: DW] : din_q;
    end

endmodule

// File: tb/tb_mem_load_port.sv
// Directed self-checking bench for mem_load_port (NCH=3 so an out-of-range
// channel is encodable, RD_LAT=2).
module tb_mem_load_port;

    localparam int DW     = 16;
    localparam int AW     = 13;
    localparam int NCH    = 3;
    localparam int RD_LAT = 2;
    localparam int CW     = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              host_strobe;
    logic              host_wr_rdb;
    logic              host_addr_memb;
    logic [CW-1:0]     host_ch;
    logic [DW-1:0]     host_din;
    logic [DW-1:0]     host_dout;
    logic              host_ack;
    logic              busy;
    logic [NCH*AW-1:0] cpu_addr;
    logic [NCH-1:0]    cpu_wen_n;
    logic [NCH*DW-1:0] cpu_wdata;
    logic [NCH*AW-1:0] mem_addr;
    logic [NCH-1:0]    mem_wen_n;
    logic [NCH*DW-1:0] mem_wdata;
    logic [NCH*DW-1:0] mem_rdata;

    int checks;
    int errors;

    mem_load_port #(.DW(DW), .AW(AW), .NCH(NCH), .RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .host_strobe    (host_strobe),
        .host_wr_rdb    (host_wr_rdb),
        .host_addr_memb (host_addr_memb),
        .host_ch        (host_ch),
        .host_din       (host_din),
        .host_dout      (host_dout),
        .host_ack       (host_ack),
        .busy           (busy),
        .cpu_addr       (cpu_addr),
        .cpu_wen_n      (cpu_wen_n),
        .cpu_wdata      (cpu_wdata),
        .mem_addr       (mem_addr),
        .mem_wen_n      (mem_wen_n),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macros: synchronous write, RD_LAT=2 registered read.
    logic [DW-1:0] mem [NCH][2**AW];
    logic [DW-1:0] p1 [NCH];
    logic [DW-1:0] p2 [NCH];

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (mem_wen_n[k] === 1'b0) mem[k][mem_addr[k*AW +: AW]] <= mem_wdata[k*DW +: DW];
            p1[k] <= mem[k][mem_addr[k*AW +: AW]];
            p2[k] <= p1[k];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < NCH; k++) mem_rdata[k*DW +: DW] = p2[k];
    end

    // Log of loader-issued memory writes.
    logic [CW-1:0] log_ch   [$];
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];

    always @(posedge clk) begin
        if (reset === 1'b1 && start === 1'b0) begin
            for (int m = 0; m < NCH; m++) begin
                if (mem_wen_n[m] === 1'b0) begin
                    log_ch.push_back(CW'(m));
                    log_addr.push_back(mem_addr[m*AW +: AW]);
                    log_data.push_back(mem_wdata[m*DW +: DW]);
                end
            end
        end
    end

    // Full four-phase transaction; lat = clock edges from strobe rise to ack.
    task automatic host_op(input logic wr, input logic am, input logic [CW-1:0] ch,
                           input logic [DW-1:0] din, output int lat, output logic busy_at_ack);
        int n;
        host_wr_rdb    = wr;
        host_addr_memb = am;
        host_ch        = ch;
        host_din       = din;
        host_strobe    = 1'b1;
        lat = 0;
        while (host_ack !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        busy_at_ack = busy;
        if (host_ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ack_rise_timeout got ack=%b required 1", host_ack);
        end
        host_strobe = 1'b0;
        n = 0;
        while (host_ack !== 1'b0 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (host_ack !== 1'b0) begin
            checks++; errors++;
            $display("FAIL ack_fall_timeout got ack=%b required 0", host_ack);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_wen_n !== 3'b111) begin errors++; $display("FAIL rst_wen got %b required 111", mem_wen_n); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_addr got %h required 0", mem_addr); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b required 0", host_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        checks++; if (host_dout !== 16'h0000) begin errors++; $display("FAIL rst_dout got %h required 0000", host_dout); end
    endtask

    task automatic test_write;
        int lat; logic b;
        log_ch.delete(); log_addr.delete(); log_data.delete();
        host_op(1'b1, 1'b1, 2'd1, 16'h0100, lat, b);
        checks++; if (lat !== 3) begin errors++; $display("FAIL addr_load_lat got %0d required 3", lat); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL busy_in_ack got %b required 1", b); end
        host_op(1'b1, 1'b0, 2'd1, 16'h1234, lat, b);
        checks++; if (lat !== 4) begin errors++; $display("FAIL mem_write_lat got %0d required 4", lat); end
        host_op(1'b1, 1'b0, 2'd1, 16'hABCD, lat, b);
        checks++; if (log_ch.size() !== 2) begin errors++; $display("FAIL write_count got %0d required 2", log_ch.size()); end
        else begin
            checks++; if (log_ch[0] !== 2'd1 || log_addr[0] !== 13'h0100 || log_data[0] !== 16'h1234) begin
                errors++; $display("FAIL write0 got ch%0d %h=%h required ch1 0100=1234", log_ch[0], log_addr[0], log_data[0]); end
            checks++; if (log_ch[1] !== 2'd1 || log_addr[1] !== 13'h0101 || log_data[1] !== 16'hABCD) begin
                errors++; $display("FAIL write1 got ch%0d %h=%h required ch1 0101=abcd", log_ch[1], log_addr[1], log_data[1]); end
        end
        host_op(1'b0, 1'b1, 2'd1, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'h0102) begin errors++; $display("FAIL addr_after_write got %h required 0102", host_dout); end
    endtask

    task automatic test_read;
        int lat; logic b;
        host_op(1'b1, 1'b1, 2'd1, 16'h0100, lat, b);
        host_op(1'b0, 1'b0, 2'd1, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'h1234) begin errors++; $display("FAIL read0 got %h required 1234", host_dout); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL read0_lat got %0d required 6", lat); end
        host_op(1'b0, 1'b0, 2'd1, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'hABCD) begin errors++; $display("FAIL read1 got %h required abcd", host_dout); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL read1_lat got %0d required 6", lat); end
        host_op(1'b0, 1'b1, 2'd1, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'h0102) begin errors++; $display("FAIL addr_after_read got %h required 0102", host_dout); end
    endtask

    task automatic test_wrap;
        int lat; logic b;
        log_ch.delete(); log_addr.delete(); log_data.delete();
        host_op(1'b1, 1'b1, 2'd0, 16'h1FFF, lat, b);
        host_op(1'b1, 1'b0, 2'd0, 16'h5A5A, lat, b);
        checks++; if (log_addr.size() !== 1 || log_addr[0] !== 13'h1FFF || log_ch[0] !== 2'd0) begin
            errors++; $display("FAIL wrap_write got n=%0d required one write ch0 at 1fff", log_addr.size()); end
        host_op(1'b0, 1'b1, 2'd0, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h required 0000", host_dout); end
    endtask

    task automatic test_invalid_ch;
        int lat; logic b;
        log_ch.delete(); log_addr.delete(); log_data.delete();
        host_op(1'b0, 1'b1, 2'd1, 16'h0000, lat, b);
        host_op(1'b1, 1'b0, 2'd3, 16'hFFFF, lat, b);
        checks++; if (log_ch.size() !== 0) begin errors++; $display("FAIL inv_write got %0d writes required 0", log_ch.size()); end
        checks++; if (lat >= 40) begin errors++; $display("FAIL inv_ack got lat %0d required completion", lat); end
        host_op(1'b0, 1'b0, 2'd3, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'h0000) begin errors++; $display("FAIL inv_read got %h required 0000", host_dout); end
        host_op(1'b1, 1'b1, 2'd3, 16'h0055, lat, b);
        host_op(1'b0, 1'b1, 2'd1, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'h0102) begin errors++; $display("FAIL inv_no_effect got %h required 0102", host_dout); end
    endtask

    task automatic test_start;
        int lat; logic b; int n;
        host_op(1'b1, 1'b1, 2'd2, 16'h0042, lat, b);
        host_wr_rdb = 1'b0; host_addr_memb = 1'b0; host_ch = 2'd2; host_strobe = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b required 1", busy); end
        cpu_addr  = {13'h0AAA, 13'h0555, 13'h1234};
        cpu_wdata = {16'h3333, 16'h2222, 16'h1111};
        cpu_wen_n = 3'b110;
        start = 1'b1;
        #1;
        checks++; if (mem_addr !== {13'h0AAA, 13'h0555, 13'h1234}) begin errors++; $display("FAIL start_addr_mux got %h", mem_addr); end
        checks++; if (mem_wen_n !== 3'b110) begin errors++; $display("FAIL start_wen_mux got %b required 110", mem_wen_n); end
        checks++; if (mem_wdata !== {16'h3333, 16'h2222, 16'h1111}) begin errors++; $display("FAIL start_wdata_mux got %h", mem_wdata); end
        cpu_wen_n = 3'b111;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || host_ack !== 1'b0) begin errors++; $display("FAIL start_abort got busy=%b ack=%b required 0 0", busy, host_ack); end
        host_strobe = 1'b0;
        repeat (4) @(posedge clk);
        host_strobe = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (host_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL start_ignore got busy=%b ack=%b required 0 0", busy, host_ack); end
        host_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1; start = 1'b0;
        @(posedge clk); #1;
        host_op(1'b0, 1'b1, 2'd2, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'h0042) begin errors++; $display("FAIL start_addr_kept got %h required 0042", host_dout); end
    endtask

    task automatic test_reset_write;
        int lat; logic b; int n;
        host_op(1'b1, 1'b1, 2'd0, 16'h0010, lat, b);
        log_ch.delete(); log_addr.delete(); log_data.delete();
        host_wr_rdb = 1'b1; host_addr_memb = 1'b0; host_ch = 2'd0; host_din = 16'h7777; host_strobe = 1'b1;
        n = 0;
        while (mem_wen_n[0] !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (mem_wen_n !== 3'b110) begin errors++; $display("FAIL rw_wen_low got %b required 110", mem_wen_n); end
        #1; reset = 1'b0; host_strobe = 1'b0;
        #1;
        checks++; if (mem_wen_n !== 3'b111) begin errors++; $display("FAIL rw_wen_async got %b required 111", mem_wen_n); end
        checks++; if (host_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rw_ctrl got ack=%b busy=%b required 0 0", host_ack, busy); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (log_ch.size() !== 0) begin errors++; $display("FAIL rw_no_write got %0d required 0", log_ch.size()); end
        host_op(1'b0, 1'b1, 2'd0, 16'h0000, lat, b);
        checks++; if (host_dout !== 16'h0000) begin errors++; $display("FAIL rw_addr_reset got %h required 0000", host_dout); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; start = 1'b0; host_strobe = 1'b0; host_wr_rdb = 1'b0;
        host_addr_memb = 1'b0; host_ch = '0; host_din = '0;
        cpu_addr = '0; cpu_wen_n = '1; cpu_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_invalid_ch();
        test_start();
        test_reset_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
